tri_bus_arbiter: RTL and testbench
==================================

Name: tri_bus_arbiter

Overview:
- Parametrised, clocked controller for a shared W-bit tri-state bus with N_CH drivers.
- Generates per-channel complementary enable pairs (E/NE) that drive tri-state NAND driver cells.
- Arbitration is round-robin with burst ownership, a hold limit and guaranteed dead turnaround cycles between owners.
- Also provides a registered snapshot of the bus data for downstream logic.

Parameters:
- N_CH, 4, number of requesting channels (2..16)
- W, 8, data width per channel
- MAX_HOLD, 4, max consecutive owned cycles per grant (>=1)
- TURN_CYC, 1, all-off cycles between owners (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_CH  per-channel bus request
- last  in  N_CH  final beat of burst from channel i
- din  in  N_CH*W  channel data, channel i at [i*W +: W]
- bus_e  out  N_CH  driver enable, one-hot or zero, registered
- bus_ne  out  N_CH  always ~bus_e
- bus_owner  out  clog2(N_CH)  index of current/last owner
- bus_q  out  W  registered copy of owner data
- bus_valid  out  1  bus_q holds a valid beat

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, bus_e=0, bus_ne=all 1, bus_owner=0, bus_q=0, bus_valid=0, hold cnt=0, turn cnt=0.
  - Round-robin pointer ptr=N_CH-1, so channel 0 wins first.
  - Enables drop with no clock edge, including mid-burst.
- States: IDLE, OWN, TURN.
- IDLE:
  - If req!=0, the next edge goes to OWN.
  - Grant g = first set req bit scanning ptr+1, ptr+2, ... modulo N_CH.
  - bus_e<=onehot(g), bus_owner<=g, ptr<=g, cnt<=1.
- OWN, owner o:
  - Release when last[o]=1, req[o]=0, or cnt==MAX_HOLD.
  - On release: next edge goes to TURN, bus_e<=0, tcnt<=1.
  - Otherwise cnt<=cnt+1.
- TURN:
  - If tcnt<TURN_CYC, tcnt<=tcnt+1.
  - Else, if req!=0, regrant as in IDLE (the pointer already excludes o first); else go to IDLE.
- Data path:
  - Each OWN cycle with req[o]=1: bus_q<=din[o], bus_valid<=1 on the next edge.
  - Otherwise bus_valid<=0 and bus_q holds its value.
  - Latency from beat to bus_q is 1 cycle.
- Boundary rules:
  - last[o] and cnt==MAX_HOLD in the same cycle produce a single release.
  - A beat with last[o]=1 is valid and is captured.
  - A beat with req[o]=0 is not captured.
  - last of non-owners is ignored.
  - Requests arriving during TURN are honoured at TURN exit.
  - The sole requester is regranted after TURN_CYC dead cycles; it never gets back-to-back ownership.
  - The pointer wraps N_CH-1 to 0.
- Invariants:
  - popcount(bus_e)<=1 at all times.
  - bus_e[i]&bus_ne[i]=0 at all times.
  - bus_e nonzero implies state OWN.
  - bus_e never transitions directly from one owner to another.

Decomposition:
- Package tri_bus_pkg holds:
  - state enum (IDLE, OWN, TURN)
  - width helper function clog2
  - default parameter constants
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N_CH], ptr.
  - Outputs: any, idx.
  - Instantiated once; it is verified standalone as well.

Test Plan (N_CH=4, W=8, MAX_HOLD=4, TURN_CYC=1):
1. Assert rst_n=0 with arbitrary req -> bus_e=0000, bus_ne=1111, bus_valid=0, bus_owner=0.
2. req=0001 held, din0=0xA5, last=0 -> bus_e=0001 for 4 cycles; bus_q=0xA5 with bus_valid=1 for 4 cycles at 1-cycle lag; then 1 cycle bus_e=0000; then bus_e=0001 again.
3. req=1111 held, last=1111 -> owners 0,1,2,3,0 in turn; each owns 1 cycle followed by 1 cycle of bus_e=0000; popcount(bus_e)<=1 throughout.
4. Channel 2 sole requester, last[2]=1 on its 4th beat -> exactly one TURN cycle; no extra beat; 4 valid captures.
5. Channel 1 owns, req[1] drops on beat 2 -> release; only 1 valid capture; bus_e=0000 the following cycle.
6. rst_n pulsed low mid-OWN between clock edges -> bus_e=0000 and bus_ne=1111 immediately. After release, req=0100 -> channel 2 granted first (ptr reset).

Source files
------------

// File: rtl/tri_bus_pkg.sv
// Shared types, width helper and default parameters for the tri-state bus arbiter.
package tri_bus_pkg;

  localparam int unsigned N_CH_DEF     = 4;
  localparam int unsigned W_DEF        = 8;
  localparam int unsigned MAX_HOLD_DEF = 4;
  localparam int unsigned TURN_CYC_DEF = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

  // Bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr+1, ptr+2, ... modulo N_CH.
module rr_pick
  import tri_bus_pkg::*;
#(
  parameter  int unsigned N_CH = N_CH_DEF,
  localparam int unsigned PW   = clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx
);

  logic [PW-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      cand = PW'((32'(ptr) + k) % N_CH);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin burst arbiter driving complementary tri-state enables, with hold limit,
// dead turnaround cycles between owners and a registered snapshot of the owner's data.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter  int unsigned N_CH     = N_CH_DEF,
  parameter  int unsigned W        = W_DEF,
  parameter  int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter  int unsigned TURN_CYC = TURN_CYC_DEF,
  localparam int unsigned PW       = clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   last,
  input  logic [N_CH*W-1:0] din,
  output logic [N_CH-1:0]   bus_e,
  output logic [N_CH-1:0]   bus_ne,
  output logic [PW-1:0]     bus_owner,
  output logic [W-1:0]      bus_q,
  output logic              bus_valid
);

  localparam int unsigned   CW       = clog2(MAX_HOLD + 1);
  localparam int unsigned   TW       = clog2(TURN_CYC + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_MAX = TW'(TURN_CYC);

  state_e          state_q, state_d;
  logic [N_CH-1:0] bus_e_q, bus_e_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [W-1:0]    data_q, data_d;
  logic            valid_q, valid_d;

  logic            pick_any;
  logic [PW-1:0]   pick_idx;
  logic            own_req;
  logic            rel;
  logic [W-1:0]    din_a [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    assign din_a[i] = din[i*W +: W];
  end

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign own_req = req[owner_q];
  // last, dropped request and hold limit collapse into one release
  assign rel     = last[owner_q] || !own_req || (cnt_q == HOLD_MAX);

  always_comb begin
    state_d = state_q;
    bus_e_d = bus_e_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = OWN;
          bus_e_d = N_CH'(1) << pick_idx;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = CW'(1);
        end
      end
      OWN: begin
        if (own_req) begin
          data_d  = din_a[owner_q];
          valid_d = 1'b1;
        end
        if (rel) begin
          state_d = TURN;
          bus_e_d = '0;
          tcnt_d  = TW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TURN: begin
        if (tcnt_q < TURN_MAX) begin
          tcnt_d = tcnt_q + TW'(1);
        end else if (pick_any) begin
          state_d = OWN;
          bus_e_d = N_CH'(1) << pick_idx;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        bus_e_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bus_e_q <= '0;
      owner_q <= '0;
      ptr_q   <= PW'(N_CH - 1);
      cnt_q   <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_e_q <= bus_e_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus_e     = bus_e_q;
  assign bus_ne    = ~bus_e_q;
  assign bus_owner = owner_q;
  assign bus_q     = data_q;
  assign bus_valid = valid_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed plus random bench for tri_bus_arbiter against a transaction-level ownership model.
module tb_tri_bus_arbiter;
  import tri_bus_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned MH   = 4;
  localparam int unsigned TC   = 1;
  localparam int unsigned PW   = clog2(N);
  localparam int unsigned DINW = N * DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, last, bus_e, bus_ne;
  logic [DINW-1:0] din;
  logic [PW-1:0]   bus_owner;
  logic [DW-1:0]   bus_q;
  logic            bus_valid;

  int vectors = 0;
  int miscompares = 0;

  // Model: current owner (-1 none), beats owned, dead cycles left, rr pointer
  int            m_own, m_ptr, m_held, m_dead, m_last_owner;
  logic [DW-1:0] m_q;
  logic          m_valid;
  logic [N-1:0]  prev_e;
  int            valid_seen;
  int            dut_grants[$];

  tri_bus_arbiter #(.N_CH(N), .W(DW), .MAX_HOLD(MH), .TURN_CYC(TC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .din       (din),
    .bus_e     (bus_e),
    .bus_ne    (bus_ne),
    .bus_owner (bus_owner),
    .bus_q     (bus_q),
    .bus_valid (bus_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own        = -1;
    m_ptr        = N - 1;
    m_held       = 0;
    m_dead       = 0;
    m_last_owner = 0;
    m_q          = '0;
    m_valid      = 1'b0;
    prev_e       = '0;
  endtask

  task automatic try_grant();
    bit found;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (!found && req[c]) begin
        found        = 1'b1;
        m_own        = c;
        m_ptr        = c;
        m_last_owner = c;
        m_held       = 0;
      end
    end
  endtask

  task automatic model_step();
    m_valid = 1'b0;
    if (m_own >= 0) begin
      if (req[m_own]) begin
        m_q     = din[m_own*DW +: DW];
        m_valid = 1'b1;
      end
      m_held++;
      if (last[m_own] || !req[m_own] || m_held == MH) begin
        m_own  = -1;
        m_dead = TC;
      end
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) try_grant();
    end else begin
      try_grant();
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] e, ne;
    e  = (m_own >= 0) ? (N'(1) << m_own) : '0;
    ne = ~e;
    chk({tag, ":bus_e"}, 64'(bus_e), 64'(e));
    chk({tag, ":bus_ne"}, 64'(bus_ne), 64'(ne));
    chk({tag, ":owner"}, 64'(bus_owner), 64'(m_last_owner));
    chk({tag, ":valid"}, 64'(bus_valid), 64'(m_valid));
    chk({tag, ":bus_q"}, 64'(bus_q), 64'(m_q));
    chk({tag, ":onehot"}, 64'($countones(bus_e) <= 1), 64'(1));
    chk({tag, ":e_and_ne"}, 64'(bus_e & bus_ne), 64'(0));
    if (prev_e != '0 && bus_e != '0)
      chk({tag, ":no_swap"}, 64'(bus_e), 64'(prev_e));
    if (prev_e == '0 && bus_e != '0) dut_grants.push_back(int'(bus_owner));
    if (bus_valid === 1'b1) valid_seen++;
    prev_e = bus_e;
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [DINW-1:0] d, input string tag);
    req  = r;
    last = l;
    din  = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    repeat (3) cycle('0, '0, DINW'($urandom), "drain");
  endtask

  initial begin
    logic [DINW-1:0] d;
    int exp3[5] = '{0, 1, 2, 3, 0};

    // 1: reset with arbitrary requests
    req  = N'($urandom) | N'(1);
    last = N'($urandom);
    din  = DINW'($urandom);
    do_reset();

    // 2: sole requester channel 0, hold limit then one dead cycle then regrant
    cycle('0, '0, DINW'($urandom), "t2_idle");
    valid_seen = 0;
    for (int i = 1; i <= 11; i++) begin
      d = DINW'($urandom);
      d[DW-1:0] = 8'hA5;
      cycle(4'b0001, 4'b0000, d, "t2");
      if (i == 5) begin
        chk("t2_valid_count", 64'(valid_seen), 64'(4));
        chk("t2_turn_gap", 64'(bus_e), 64'(0));
      end
      if (i == 6) chk("t2_regrant", 64'(bus_e), 64'(1));
    end

    // 3: all request with last every beat -> strict rotation from channel 0
    do_reset();
    dut_grants.delete();
    repeat (10) cycle(4'b1111, 4'b1111, DINW'($urandom), "t3");
    chk("t3_grant_count", 64'(dut_grants.size() >= 5), 64'(1));
    for (int i = 0; i < 5; i++)
      if (i < dut_grants.size()) chk("t3_grant_order", 64'(dut_grants[i]), 64'(exp3[i]));
    drain();

    // 4: channel 2 alone, last on 4th beat coincides with hold limit
    valid_seen = 0;
    cycle(4'b0100, 4'b0000, DINW'($urandom), "t4_grant");
    for (int b = 1; b <= 4; b++)
      cycle(4'b0100, (b == 4) ? 4'b0100 : 4'b0000, DINW'($urandom), "t4_beat");
    chk("t4_single_turn", 64'(bus_e), 64'(0));
    cycle(4'b0100, 4'b0000, DINW'($urandom), "t4_regrant");
    chk("t4_regrant_e", 64'(bus_e), 64'(4'b0100));
    chk("t4_valid_count", 64'(valid_seen), 64'(4));
    cycle(4'b0000, 4'b0000, DINW'($urandom), "t4_drop");
    drain();

    // 5: channel 1 drops request on beat 2
    valid_seen = 0;
    cycle(4'b0010, 4'b0000, DINW'($urandom), "t5_grant");
    cycle(4'b0010, 4'b0000, DINW'($urandom), "t5_beat1");
    cycle(4'b0000, 4'b0000, DINW'($urandom), "t5_beat2");
    chk("t5_release", 64'(bus_e), 64'(0));
    cycle(4'b0000, 4'b0000, DINW'($urandom), "t5_after");
    chk("t5_valid_count", 64'(valid_seen), 64'(1));
    drain();

    // 6: async reset mid-burst between edges, then pointer restarts
    cycle(4'b1000, 4'b0000, DINW'($urandom), "t6_grant");
    cycle(4'b1000, 4'b0000, DINW'($urandom), "t6_own");
    #2;
    do_reset();
    cycle(4'b0100, 4'b0000, DINW'($urandom), "t6_after");
    chk("t6_owner", 64'(bus_owner), 64'(2));
    chk("t6_e", 64'(bus_e), 64'(4'b0100));
    drain();

    // Random traffic with occasional mid-run resets
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom), N'($urandom) & N'($urandom), DINW'($urandom), "rand");
      if ($urandom_range(0, 79) == 0) begin
        #2;
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
